// File: rtl/ticket_dispatcher.sv
// ticket_dispatcher: issues queue tickets on button presses and calls waiting
// tickets, in order, to the lowest-index open idle service counter.
module ticket_dispatcher #(
  parameter int N_CNT          = 5,
  parameter int NUM_W          = 6,
  parameter int CALL_W         = 3,
  parameter int SERVICE_CYCLES = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     button,
  input  logic [N_CNT-1:0]         counter_open,
  input  logic [N_CNT-1:0]         counter_done,
  output logic [NUM_W-1:0]         current_number,
  output logic [NUM_W-1:0]         number_service,
  output logic [CALL_W-1:0]        counter_call,
  output logic                     call_valid,
  output logic [N_CNT-1:0]         counter_busy,
  output logic [N_CNT*NUM_W-1:0]   service_numbers,
  output logic [NUM_W-1:0]         waiting_count,
  output logic                     queue_full,
  output logic                     ticket_reject
);

  // Timer holds SERVICE_CYCLES-1 down to 0; busy drops on the edge it reads 0.
  localparam int TMR_W = (SERVICE_CYCLES > 1) ? $clog2(SERVICE_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(SERVICE_CYCLES - 1);
  localparam logic [NUM_W-1:0] NUM_MAX  = '1;

  logic              btn_q;
  logic              press;
  logic              accept;
  logic              found;
  logic              dispatch;
  logic [CALL_W-1:0] sel_idx;
  logic [TMR_W-1:0]  timer [N_CNT];

  // Ticket numbers skip 0, which means "none".
  function automatic logic [NUM_W-1:0] next_num(input logic [NUM_W-1:0] n);
    return (n == NUM_MAX) ? NUM_W'(1) : n + NUM_W'(1);
  endfunction

  assign press      = button & ~btn_q;
  assign queue_full = (waiting_count == NUM_MAX);
  assign accept     = press & ~queue_full;

  // Pick the lowest-index counter that is open and idle.
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    for (int unsigned i = 0; i < N_CNT; i++) begin
      if (!found && counter_open[i] && !counter_busy[i]) begin
        found   = 1'b1;
        sel_idx = CALL_W'(i);
      end
    end
    dispatch = found && (waiting_count != '0);
  end

  // Button edge detection, ticket issue and waiting-queue bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q          <= 1'b0;
      current_number <= '0;
      waiting_count  <= '0;
      ticket_reject  <= 1'b0;
    end else begin
      btn_q         <= button;
      ticket_reject <= press & queue_full;
      if (accept)
        current_number <= next_num(current_number);
      case ({accept, dispatch})
        2'b10:   waiting_count <= waiting_count + NUM_W'(1);
        2'b01:   waiting_count <= waiting_count - NUM_W'(1);
        default: waiting_count <= waiting_count;
      endcase
    end
  end

  // Call announcement registers; they hold between calls.
  always_ff @(posedge clk) begin
    if (rst) begin
      number_service <= '0;
      counter_call   <= '0;
      call_valid     <= 1'b0;
    end else begin
      call_valid <= dispatch;
      if (dispatch) begin
        number_service <= next_num(number_service);
        counter_call   <= sel_idx;
      end
    end
  end

  // Per-counter service state: claim on dispatch, release on timeout or done.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter_busy    <= '0;
      service_numbers <= '0;
      for (int unsigned i = 0; i < N_CNT; i++)
        timer[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CNT; i++) begin
        if (dispatch && (sel_idx == CALL_W'(i))) begin
          counter_busy[i]                   <= 1'b1;
          timer[i]                          <= TMR_LOAD;
          service_numbers[i*NUM_W +: NUM_W] <= next_num(number_service);
        end else if (counter_busy[i]) begin
          if (counter_done[i] || (timer[i] == '0))
            counter_busy[i] <= 1'b0;
          else
            timer[i] <= timer[i] - TMR_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/ticket_dispatcher.md
Name: ticket_dispatcher

Overview:
Parametrised queue-ticket dispatcher that generalises the fixed five-counter response system to N_CNT service counters.
- A customer button press issues the next ticket number.
- Waiting tickets are called, in order, to the lowest-index open idle counter.
- Adds per-counter open/close control, early release by an operator, queue-full rejection and a live waiting count.
- Sits between the button debouncer and the display/annunciator logic.

Parameters:
N_CNT, 5, number of service counters (1..8)
NUM_W, 6, ticket number width; valid tickets are 1..2^NUM_W-1, 0 means "none"
CALL_W, 3, width of counter index; 2^CALL_W >= N_CNT
SERVICE_CYCLES, 8, cycles a counter stays busy after a call unless released early (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
button  in  1  ticket request, synchronous level; one ticket per low-to-high transition
counter_open  in  N_CNT  bit i high: counter i may receive new calls
counter_done  in  N_CNT  bit i high while counter i busy: release early
current_number  out  NUM_W  last ticket issued
number_service  out  NUM_W  last ticket called
counter_call  out  CALL_W  index of counter receiving the last call
call_valid  out  1  one-cycle pulse when a call is made
counter_busy  out  N_CNT  bit i high while counter i serves a ticket
service_numbers  out  N_CNT*NUM_W  ticket held/last served by counter i, slice [i*NUM_W +: NUM_W]
waiting_count  out  NUM_W  tickets issued but not yet called
queue_full  out  1  waiting_count == 2^NUM_W-1
ticket_reject  out  1  one-cycle pulse when a press is refused because the queue is full

Behaviour:
- Reset:
  - All outputs are 0.
  - The button edge register is cleared to 0, so a button held high through reset issues one ticket on the first cycle after reset.
  - Reset mid-operation aborts all service and clears the queue in the same edge.
- Ticket issue:
  - A press is detected when button=1 at an edge and was 0 at the previous edge.
  - If not queue_full, current_number increments at that edge. Wrap: 2^NUM_W-1 -> 1, never 0.
  - Also at that edge, waiting_count +1.
  - If queue_full, the press is dropped, ticket_reject pulses for one cycle and current_number holds.
- Dispatch: evaluated each cycle on registered state.
  - Condition: waiting_count>0 and at least one counter with counter_open=1 and counter_busy=0.
  - The lowest such index i is chosen.
  - At the next edge: number_service increments with the same wrap rule, service_numbers[i] is set to the new number_service, counter_busy[i] is set, the timer is loaded, counter_call=i, call_valid=1 and waiting_count -1.
  - At most one dispatch per cycle.
- Latency: a ticket issued at edge k is dispatched at edge k+1 at the earliest.
- Simultaneous issue and dispatch in one cycle: waiting_count is unchanged, and both numbers advance.
- Service timing:
  - counter_busy[i] stays high for exactly SERVICE_CYCLES cycles.
  - It clears at the edge where the timer expires.
  - The counter is eligible again from the following cycle, so there is at least one idle cycle between calls.
- Early release:
  - counter_done[i]=1 while busy clears busy[i] at the next edge.
  - counter_done on an idle counter is ignored.
- Close while busy: service completes normally, and the counter is not called again until reopened.
- service_numbers[i] retains its value after release, for the display.
- counter_call and number_service hold between calls.

Test Plan:
1. Reset with button=1 held, release rst -> all outputs 0 while rst high; the cycle after reset, current_number=1 (one ticket), no further tickets while held.
2. Defaults. Two presses 2 cycles apart -> current_number 1 then 2. Call 1: counter_call=0, service_numbers[0]=1. Call 2: counter_call=1, service_numbers[1]=2. call_valid pulses twice. waiting_count returns to 0.
3. Seven rapid presses with all open -> counters 0..4 hold 1..5, waiting_count=2. Counter 0 goes idle 8 cycles after its call, and one cycle later receives ticket 6.
4. counter_open=5'b11110, one press -> counter_call=1. Assert counter_done[1] 3 cycles into service -> busy[1] clears next edge, and the next ticket goes to counter 1.
5. NUM_W=3, counter_open=0, 8 presses -> after 7, queue_full=1, waiting_count=7. 8th press: ticket_reject pulse, current_number stays 7. Open counter 0 -> ticket 1 called. Next press: current_number wraps to 1, queue_full=1 again.
6. Assert rst with 3 counters busy and waiting_count=4 -> all outputs 0 next cycle. The next press issues ticket 1 and it is called to counter 0.
